mem8_arb_ctrl: RTL and testbench

MEM8_ARB_CTRL -- requirements
Module: mem8_arb_ctrl

---
 rtl/mem8_defs.sv | 15 +
 rtl/mem8_rr_pick.sv | 18 +
 rtl/mem8_arb_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem8_arb_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem8_defs.sv
// mem8_defs -- shared definitions for the 8-bit memory arbiter family.
// Holds the default data/address widths and the controller state encoding,
// so that mem8_arb_ctrl and memory8bit agree on both.
package mem8_defs;

    localparam int DW_DEF = 8;   // data width
    localparam int AW_DEF = 4;   // address width (16 words)

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_e;

endpackage

// File: rtl/mem8_rr_pick.sv
// mem8_rr_pick -- two-way round-robin winner selection (combinational).
// Ports:
//   a_req, b_req : requests from the two sides
//   ptr          : priority pointer, 0 favours A, 1 favours B
//   sel_a, sel_b : one-hot winner (both 0 when nobody requests)
module mem8_rr_pick (
    input  logic a_req,
    input  logic b_req,
    input  logic ptr,
    output logic sel_a,
    output logic sel_b
);

    // A lone requester always wins; on a tie the pointer decides.
    assign sel_a = a_req & (~b_req | ~ptr);
    assign sel_b = b_req & (~a_req |  ptr);

endmodule

// File: rtl/mem8_arb_ctrl.sv
// mem8_arb_ctrl -- arbitrates two requesters (A, B) onto one synchronous
// single-port memory.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   a_/b_ req, we, addr, wdata    : requester commands (req held until gnt)
//   a_/b_ gnt                     : one-cycle grant, issued with the mem strobe
//   a_/b_ rvalid, rdata           : one-cycle read return to the owner
//   busy                          : high whenever the FSM is not IDLE
//   mem_en, mem_we, mem_addr, mem_wdata : memory command (strobe only in ISSUE)
//   mem_rdata                     : memory read data, valid the cycle after strobe
// Timing: read  req@N -> gnt@N+1 -> rvalid@N+3
//         write req@N -> gnt/write@N+1 -> IDLE@N+2
module mem8_arb_ctrl
    import mem8_defs::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_d, state_q;
    logic          ptr_d, ptr_q;
    logic          owner_d, owner_q;     // 0 = A, 1 = B
    logic          we_d, we_q;
    logic          a_gnt_d, a_gnt_q, b_gnt_d, b_gnt_q;
    logic          a_rvalid_d, a_rvalid_q, b_rvalid_d, b_rvalid_q;
    logic          busy_d, busy_q;
    logic          mem_en_d, mem_en_q, mem_we_d, mem_we_q;
    logic [AW-1:0] mem_addr_d, mem_addr_q;
    logic [DW-1:0] mem_wdata_d, mem_wdata_q;
    logic [DW-1:0] rdata_d, rdata_q;
    logic          sel_a, sel_b;

    mem8_rr_pick u_pick (
        .a_req (a_req),
        .b_req (b_req),
        .ptr   (ptr_q),
        .sel_a (sel_a),
        .sel_b (sel_b)
    );

    // Next-state and next-output logic. Strobes and pulses default to 0 so
    // they last exactly one cycle; the command registers hold their value.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_a || sel_b) begin
                    state_d     = ST_ISSUE;
                    owner_d     = sel_b;
                    we_d        = sel_b ? b_we    : a_we;
                    mem_addr_d  = sel_b ? b_addr  : a_addr;
                    mem_wdata_d = sel_b ? b_wdata : a_wdata;
                    // Outputs are registered, so the ISSUE-cycle strobe and
                    // grant are loaded on the edge that enters ISSUE.
                    a_gnt_d     = sel_a;
                    b_gnt_d     = sel_b;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_b ? b_we : a_we;
                    ptr_d       = sel_a;   // favour the loser next time
                end
            end
            ST_ISSUE: begin
                state_d = we_q ? ST_IDLE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                rdata_d    = mem_rdata;
                a_rvalid_d = ~owner_q;
                b_rvalid_d =  owner_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            a_gnt_q     <= a_gnt_d;
            b_gnt_q     <= b_gnt_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem8_arb_ctrl.sv
// Directed bench for mem8_arb_ctrl. Inputs are driven and outputs sampled on
// the falling edge; a small behavioural memory answers the memory port.
module tb_mem8_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [3:0] a_addr, b_addr, mem_addr;
    logic [7:0] a_wdata, b_wdata, rdata, mem_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid, busy, mem_en, mem_we;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] mem [16] = '{default: 8'h00};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem8_arb_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .a_gnt     (a_gnt),
        .b_gnt     (b_gnt),
        .a_rvalid  (a_rvalid),
        .b_rvalid  (b_rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        tick(); tick();
        total++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, busy, mem_en, mem_we} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {a_gnt, b_gnt, a_rvalid, b_rvalid, busy, mem_en, mem_we});
        end
        total++;
        if ({rdata, mem_addr, mem_wdata} !== 20'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=00000", {rdata, mem_addr, mem_wdata});
        end
        rst_n = 1'b1;
    endtask

    // A writes A5 to address 3; first edge after reset release must act as IDLE.
    task automatic test_write;
        a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 8'hA5;
        tick();
        total++;
        if ({a_gnt, b_gnt, mem_en, mem_we, busy} !== 5'b10111) begin
            bad++;
            $display("FAIL wr_gnt got=%b want=10111", {a_gnt, b_gnt, mem_en, mem_we, busy});
        end
        total++;
        if ({mem_addr, mem_wdata} !== {4'd3, 8'hA5}) begin
            bad++;
            $display("FAIL wr_cmd got=%h want=3a5", {mem_addr, mem_wdata});
        end
        a_req = 0;
        tick();
        total++;
        if ({busy, mem_en, mem_we, a_gnt} !== 4'b0) begin
            bad++;
            $display("FAIL wr_done got=%b want=0000", {busy, mem_en, mem_we, a_gnt});
        end
    endtask

    // B reads address 3: gnt at N+1, RDWAIT at N+2, rvalid/rdata at N+3.
    task automatic test_read;
        b_req = 1; b_we = 0; b_addr = 4'd3;
        tick();
        total++;
        if ({b_gnt, a_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 4'd3}) begin
            bad++;
            $display("FAIL rd_gnt got=%b want=10100011", {b_gnt, a_gnt, mem_en, mem_we, mem_addr});
        end
        b_req = 0;
        tick();
        total++;
        if ({b_rvalid, a_rvalid, busy, mem_en} !== 4'b0010) begin
            bad++;
            $display("FAIL rd_wait got=%b want=0010", {b_rvalid, a_rvalid, busy, mem_en});
        end
        tick();
        total++;
        if ({b_rvalid, a_rvalid, busy} !== 3'b100 || rdata !== 8'hA5) begin
            bad++;
            $display("FAIL rd_data got=%b/%h want=100/a5", {b_rvalid, a_rvalid, busy}, rdata);
        end
        tick();
        total++;
        if ({b_rvalid, a_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL rd_pulse got=%b want=00", {b_rvalid, a_rvalid});
        end
    endtask

    // From reset, both sides hold write requests: grants must go A,B,A,B.
    task automatic test_round_robin;
        logic [3:0] order;
        int         n;
        order = 4'b0; n = 0;
        rst_n = 0; tick(); rst_n = 1;
        a_req = 1; a_we = 1; a_addr = 4'd0; a_wdata = 8'h11;
        b_req = 1; b_we = 1; b_addr = 4'd1; b_wdata = 8'h22;
        for (int c = 0; c < 20 && n < 4; c++) begin
            tick();
            if (a_gnt && b_gnt) begin
                total++; bad++;
                $display("FAIL rr_both_gnt cycle=%0d got=11 want=one-hot", c);
            end else if (a_gnt || b_gnt) begin
                order[n] = b_gnt;
                n++;
            end
        end
        a_req = 0; b_req = 0;
        total++;
        if (n != 4 || order !== 4'b1010) begin
            bad++;
            $display("FAIL rr_order got=%0d grants order=%b want=4 grants order=1010 (B=1, first in bit0)",
                     n, order);
        end
        tick(); tick();
    endtask

    // Reset in RDWAIT of A's read: outputs drop at once, access is dropped,
    // and the pointer is back to favouring A.
    task automatic test_reset_mid;
        a_req = 1; a_we = 0; a_addr = 4'd3;
        tick();
        a_req = 0;
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre busy got=%b want=1", busy);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, busy, mem_en, mem_we} !== 7'b0 ||
            {rdata, mem_addr, mem_wdata} !== 20'h0) begin
            bad++;
            $display("FAIL rst_async got=%b/%h want=0000000/00000",
                     {a_gnt, b_gnt, a_rvalid, b_rvalid, busy, mem_en, mem_we},
                     {rdata, mem_addr, mem_wdata});
        end
        tick();
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({a_rvalid, b_rvalid, a_gnt, b_gnt} !== 4'b0) begin
                bad++;
                $display("FAIL rst_dropped cycle=%0d got=%b want=0000", c, {a_rvalid, b_rvalid, a_gnt, b_gnt});
            end
        end
        a_req = 1; a_we = 1; a_addr = 4'd7; a_wdata = 8'h33;
        b_req = 1; b_we = 1; b_addr = 4'd8; b_wdata = 8'h44;
        tick();
        total++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL rst_tie got=%b want=10", {a_gnt, b_gnt});
        end
        a_req = 0; b_req = 0;
        tick();
    endtask

    // B arrives while A's read is in ISSUE: no B grant until after A's rvalid.
    task automatic test_busy_ignore;
        a_req = 1; a_we = 0; a_addr = 4'd7;
        tick();
        total++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL busy_a_gnt got=%b want=10", {a_gnt, b_gnt});
        end
        a_req = 0;
        b_req = 1; b_we = 1; b_addr = 4'd9; b_wdata = 8'h99;
        tick();
        total++;
        if (b_gnt !== 1'b0) begin
            bad++;
            $display("FAIL busy_b_rdwait got=%b want=0", b_gnt);
        end
        tick();
        total++;
        if ({a_rvalid, b_gnt, busy} !== 3'b100 || rdata !== 8'h33) begin
            bad++;
            $display("FAIL busy_a_rvalid got=%b/%h want=100/33", {a_rvalid, b_gnt, busy}, rdata);
        end
        tick();
        total++;
        if ({b_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 4'd9, 8'h99}) begin
            bad++;
            $display("FAIL busy_b_gnt got=%h want=%h", {b_gnt, mem_en, mem_we, mem_addr, mem_wdata},
                     {3'b111, 4'd9, 8'h99});
        end
        b_req = 0;
        tick();
        total++;
        if ({busy, b_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL busy_b_done got=%b want=00", {busy, b_gnt});
        end
    endtask

    // Top address: write 5A to 15, read it back.
    task automatic test_top_addr;
        a_req = 1; a_we = 1; a_addr = 4'd15; a_wdata = 8'h5A;
        tick();
        a_req = 0;
        tick();
        a_req = 1; a_we = 0; a_addr = 4'd15;
        tick();
        total++;
        if ({a_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 4'd15}) begin
            bad++;
            $display("FAIL top_rd_gnt got=%b want=1101111", {a_gnt, mem_en, mem_we, mem_addr});
        end
        a_req = 0;
        tick();
        tick();
        total++;
        if (a_rvalid !== 1'b1 || rdata !== 8'h5A) begin
            bad++;
            $display("FAIL top_rd_data got=%b/%h want=1/5a", a_rvalid, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_mid();
        test_busy_ignore();
        test_top_addr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
